pll_lock_seq: RTL and testbench

- Sequences the reset and lock of a single PLL wrapper (50 MHz refclk to 25 MHz outclk) in the MiSTer top level.
- Pulses the PLL reset and waits for a filtered, stable `locked`.
- Releases a downstream core reset only after lock has settled.
- On lock loss or lock timeout, re-runs the PLL with bounded retries; flags permanent failure.
- Runs on the PLL reference clock, never on the PLL output.

---
 rtl/pll_lock_seq_if.sv | 21 ++
 rtl/pll_lock_seq.sv | 151 +++++++++++++++
 tb/tb_pll_lock_seq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_seq_if.sv
// Control bundle between the PLL lock sequencer and the PLL wrapper / downstream core.
// master = sequencer side, slave = the environment driving soft_rst and pll_locked.
interface pll_lock_seq_if;
  logic       soft_rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       rst_out;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;

  modport master (
    input  soft_rst, pll_locked,
    output pll_rst, rst_out, ready, fail, retry_cnt
  );

  modport slave (
    output soft_rst, pll_locked,
    input  pll_rst, rst_out, ready, fail, retry_cnt
  );
endinterface

// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer on the reference clock: pulses pll_rst, filters locked,
// releases the downstream reset after settling, retries on timeout and flags FAIL.
//
// state    | meaning
// S_RESET  | pll_rst asserted for RST_CYCLES cycles
// S_WAIT   | waiting for LOCK_FILTER consecutive synchronized lock cycles
// S_SETTLE | lock held for RELEASE_DLY cycles before releasing rst_out
// S_RUN    | core running, any lock drop restarts the sequence
// S_FAIL   | retries exhausted, waits for soft_rst or rst_n
module pll_lock_seq #(
  parameter int unsigned RST_CYCLES  = 16,
  parameter int unsigned LOCK_FILTER = 64,
  parameter int unsigned TIMEOUT     = 1048576,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RELEASE_DLY = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pll_lock_seq_if.master bus
);

  localparam int unsigned CNT_MAX = (RST_CYCLES > RELEASE_DLY) ? RST_CYCLES : RELEASE_DLY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FLT_W   = $clog2(LOCK_FILTER + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DLY - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(LOCK_FILTER - 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [FLT_W-1:0] flt_q, flt_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       retry_inc;
  logic             lk_meta_q, lk_s_q;
  logic             pll_rst_q, rst_out_q, ready_q, fail_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    flt_d     = flt_q;
    retry_d   = retry_q;
    retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;

    if (bus.soft_rst) begin
      state_d = S_RESET;
      cnt_d   = '0;
      tmo_d   = '0;
      flt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            tmo_d   = '0;
            flt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT, S_SETTLE: begin
          tmo_d = tmo_q + 1'b1;
          // timeout wins over any lock/settle progress on the same edge
          if (tmo_q == TMO_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            tmo_d   = '0;
            flt_d   = '0;
            state_d = (32'(retry_inc) < MAX_RETRY) ? S_RESET : S_FAIL;
          end else if (state_q == S_WAIT) begin
            if (!lk_s_q) begin
              flt_d = '0;
            end else if (flt_q == FLT_LAST) begin
              state_d = S_SETTLE;
              cnt_d   = '0;
            end else begin
              flt_d = flt_q + 1'b1;
            end
          end else begin
            if (!lk_s_q) begin
              state_d = S_WAIT;
              flt_d   = '0;
            end else if (cnt_q == REL_LAST) begin
              state_d = S_RUN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (!lk_s_q) begin
            state_d = S_RESET;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      tmo_q     <= '0;
      flt_q     <= '0;
      retry_q   <= '0;
      lk_meta_q <= 1'b0;
      lk_s_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      rst_out_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      flt_q     <= flt_d;
      retry_q   <= retry_d;
      lk_meta_q <= bus.pll_locked;
      lk_s_q    <= lk_meta_q;
      pll_rst_q <= (state_d == S_RESET);
      rst_out_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      fail_q    <= (state_d == S_FAIL);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.rst_out   = rst_out_q;
  assign bus.ready     = ready_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Bench for pll_lock_seq: directed scenarios plus random lock/reset activity, every
// cycle compared against a phase/elapsed-time model of the sequencing rules.
module tb_pll_lock_seq;

  localparam int RST_CYCLES  = 4;
  localparam int LOCK_FILTER = 8;
  localparam int TIMEOUT     = 100;
  localparam int MAX_RETRY   = 2;
  localparam int RELEASE_DLY = 4;

  localparam int P_RST = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_FAIL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  pll_lock_seq_if bif ();

  pll_lock_seq #(
    .RST_CYCLES (RST_CYCLES),
    .LOCK_FILTER(LOCK_FILTER),
    .TIMEOUT    (TIMEOUT),
    .MAX_RETRY  (MAX_RETRY),
    .RELEASE_DLY(RELEASE_DLY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  // reference model: current phase, time spent in it, lock run length and attempt age
  int m_ph = P_RST;
  int m_age = 0;
  int m_run = 0;
  int m_held = 0;
  int m_elapsed = 0;
  int m_retries = 0;
  bit m_pipe[$] = '{1'b0, 1'b0};

  task automatic model_step();
    bit lk;
    if (!rst_n) begin
      m_pipe = '{1'b0, 1'b0};
      m_ph = P_RST; m_age = 0; m_retries = 0;
      return;
    end
    lk = m_pipe.pop_front();
    m_pipe.push_back(bif.pll_locked);
    if (bif.soft_rst) begin
      m_ph = P_RST; m_age = 0; m_retries = 0;
      return;
    end
    case (m_ph)
      P_RST: begin
        m_age++;
        if (m_age == RST_CYCLES) begin
          m_ph = P_WAIT; m_run = 0; m_elapsed = 0;
        end
      end
      P_WAIT, P_SETTLE: begin
        m_elapsed++;
        if (m_elapsed == TIMEOUT) begin
          m_retries = (m_retries + 1 > 3) ? 3 : m_retries + 1;
          m_ph = (m_retries < MAX_RETRY) ? P_RST : P_FAIL;
          m_age = 0;
        end else if (m_ph == P_WAIT) begin
          m_run = lk ? m_run + 1 : 0;
          if (m_run == LOCK_FILTER) begin
            m_ph = P_SETTLE; m_held = 0;
          end
        end else if (!lk) begin
          m_ph = P_WAIT; m_run = 0;
        end else begin
          m_held++;
          if (m_held == RELEASE_DLY) m_ph = P_RUN;
        end
      end
      P_RUN: if (!lk) begin
        m_ph = P_RST; m_age = 0; m_retries = 0;
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
  endtask

  function automatic int exp_vec();
    return ((m_ph == P_RST) ? 32 : 0) + ((m_ph != P_RUN) ? 16 : 0) +
           ((m_ph == P_RUN) ? 8 : 0) + ((m_ph == P_FAIL) ? 4 : 0) + m_retries;
  endfunction

  function automatic int got_vec();
    return int'({bif.pll_rst, bif.rst_out, bif.ready, bif.fail, bif.retry_cnt});
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("cycle_outputs", got_vec(), exp_vec());
  endtask

  task automatic wait_ready(input int bound, output int n);
    n = 0;
    while (bif.ready !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bif.soft_rst   = 1'b0;
    bif.pll_locked = 1'b0;

    // reset values
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_vector", got_vec(), 6'b110000);
    rst_n = 1'b1;

    // nominal lock: locked rises before the 10th edge after release
    repeat (3) tick();
    chk("pll_rst_held", int'(bif.pll_rst), 1);
    tick();
    chk("pll_rst_dropped", int'(bif.pll_rst), 0);
    repeat (5) tick();
    bif.pll_locked = 1'b1;
    wait_ready(100, n);
    chk("nominal_ticks_to_run", n, 14);
    chk("nominal_rst_out", int'(bif.rst_out), 0);
    chk("nominal_retry", int'(bif.retry_cnt), 0);

    // glitch during filtering: high 5, low 1, then high
    bif.pll_locked = 1'b0;
    do_reset();
    repeat (9) tick();
    bif.pll_locked = 1'b1;
    repeat (5) tick();
    bif.pll_locked = 1'b0;
    tick();
    bif.pll_locked = 1'b1;
    wait_ready(100, n);
    chk("glitch_ticks_to_run", n, 14);

    // one-cycle lock loss in RUN
    bif.pll_locked = 1'b0;
    tick();
    bif.pll_locked = 1'b1;
    tick();
    chk("loss_still_ready", int'(bif.ready), 1);
    tick();
    chk("loss_ready", int'(bif.ready), 0);
    chk("loss_pll_rst", int'(bif.pll_rst), 1);
    chk("loss_retry", int'(bif.retry_cnt), 0);
    wait_ready(100, n);
    chk("relock_ticks_to_run", n, 16);

    // two timeouts to FAIL
    bif.pll_locked = 1'b0;
    do_reset();
    repeat (104) tick();
    chk("tmo1_retry", int'(bif.retry_cnt), 1);
    chk("tmo1_pll_rst", int'(bif.pll_rst), 1);
    repeat (103) tick();
    chk("tmo2_not_yet_fail", int'(bif.fail), 0);
    tick();
    chk("tmo2_fail", int'(bif.fail), 1);
    chk("tmo2_pll_rst", int'(bif.pll_rst), 0);
    chk("tmo2_retry", int'(bif.retry_cnt), 2);
    repeat (50) tick();
    chk("fail_rst_out", int'(bif.rst_out), 1);
    chk("fail_sticky", int'(bif.fail), 1);

    // soft_rst out of FAIL
    bif.soft_rst   = 1'b1;
    bif.pll_locked = 1'b1;
    tick();
    bif.soft_rst = 1'b0;
    chk("soft_fail_clr", int'(bif.fail), 0);
    chk("soft_retry_clr", int'(bif.retry_cnt), 0);
    chk("soft_pll_rst", int'(bif.pll_rst), 1);
    wait_ready(100, n);
    chk("soft_ticks_to_run", n, 16);

    // rst_n during SETTLE
    do_reset();
    repeat (14) tick();
    chk("settle_not_ready", int'(bif.ready), 0);
    rst_n = 1'b0;
    tick();
    chk("settle_abort_vector", got_vec(), 6'b110000);
    rst_n = 1'b1;

    // soft_rst on the same edge as the second timeout
    bif.pll_locked = 1'b0;
    repeat (104) tick();
    chk("tmo_pre_retry", int'(bif.retry_cnt), 1);
    repeat (103) tick();
    bif.soft_rst = 1'b1;
    tick();
    bif.soft_rst = 1'b0;
    chk("soft_vs_tmo_fail", int'(bif.fail), 0);
    chk("soft_vs_tmo_retry", int'(bif.retry_cnt), 0);
    chk("soft_vs_tmo_pll_rst", int'(bif.pll_rst), 1);

    // random lock activity with occasional soft_rst and rst_n pulses
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      bif.pll_locked = seg[0];
      len = seg[0] ? int'($urandom_range(1, 120)) : int'($urandom_range(1, 25));
      for (int k = 0; k < len; k++) begin
        bif.soft_rst = ($urandom_range(0, 99) == 0);
        rst_n        = ($urandom_range(0, 199) != 0);
        tick();
      end
    end
    bif.soft_rst = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
